// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for the PE grid: one K-step (activation column + weight row)
// per handshake, lane r/c delayed r/c extra cycles. Optional macro: SKEW_FEEDER_STALL_CNT_EN.
module systolic_skew_feeder #(
    parameter int INPUT_WIDTH  = 32,
    parameter int WEIGHT_WIDTH = 32,
    parameter int NUM_ROWS     = 16,
    parameter int NUM_COLS     = 16,
    parameter int K_WIDTH      = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic [K_WIDTH-1:0]                     k_len_i,
    input  logic                                   vec_valid_i,
    output logic                                   vec_ready_o,
    input  logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]   in_vec_i,
    input  logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0]  w_vec_i,
    output logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]   input_o,
    output logic [NUM_ROWS-1:0]                    input_valid_o,
    output logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0]  weight_o,
    output logic [NUM_COLS-1:0]                    weight_valid_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [31:0]                            stall_cnt_o,
    output logic [1:0]                             dbg_state_o
);

    localparam int M  = (NUM_ROWS > NUM_COLS) ? NUM_ROWS : NUM_COLS;
    localparam int DW = (M > 1) ? $clog2(M) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((M > 1) ? (M - 2) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [K_WIDTH-1:0] r_k_len;
    logic [K_WIDTH-1:0] r_step;
    logic [DW-1:0]      r_drain;
    logic               w_accept;
    logic               w_last_step;
    logic               w_start_taken;

    // Handshake: a vector transfers on any cycle where vec_valid_i and vec_ready_o
    // are both high; ready depends only on state, never on vec_valid_i.
    assign w_accept      = (r_state == STREAM) && vec_valid_i;
    assign w_last_step   = (r_step == (r_k_len - K_WIDTH'(1)));
    assign w_start_taken = (r_state == IDLE) && start_i;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_next = (k_len_i != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (w_accept && w_last_step) begin
                    w_state_next = (M > 1) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_k_len <= '0;
            r_step  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_taken) begin
                r_k_len <= k_len_i;
                r_step  <= '0;
            end else if (w_accept) begin
                r_step <= r_step + K_WIDTH'(1);
            end
            r_drain <= (r_state == DRAIN) ? (r_drain + DW'(1)) : '0;
        end
    end

    assign vec_ready_o = (r_state == STREAM);
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign dbg_state_o = r_state;

`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_start_taken) begin
            r_stall_cnt <= '0;
        end else if ((r_state == STREAM) && !vec_valid_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

    // Lane r is a chain of r+1 registers; data and valid shift together every cycle.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        logic [INPUT_WIDTH-1:0] r_data [0:r];
        logic                   r_vld  [0:r];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i <= r; i++) begin
                    r_data[i] <= '0;
                    r_vld[i]  <= 1'b0;
                end
            end else begin
                r_data[0] <= in_vec_i[r];
                r_vld[0]  <= w_accept;
                for (int i = 1; i <= r; i++) begin
                    r_data[i] <= r_data[i-1];
                    r_vld[i]  <= r_vld[i-1];
                end
            end
        end

        assign input_o[r]       = r_data[r];
        assign input_valid_o[r] = r_vld[r];
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        logic [WEIGHT_WIDTH-1:0] r_data [0:c];
        logic                    r_vld  [0:c];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i <= c; i++) begin
                    r_data[i] <= '0;
                    r_vld[i]  <= 1'b0;
                end
            end else begin
                r_data[0] <= w_vec_i[c];
                r_vld[0]  <= w_accept;
                for (int i = 1; i <= c; i++) begin
                    r_data[i] <= r_data[i-1];
                    r_vld[i]  <= r_vld[i-1];
                end
            end
        end

        assign weight_o[c]       = r_data[c];
        assign weight_valid_o[c] = r_vld[c];
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the PE grid: accepts one K-step per handshake (a column of NUM_ROWS activations plus a row of NUM_COLS weights) and emits them diagonally skewed.
- Row lane r is delayed r extra cycles and column lane c is delayed c extra cycles, so operands meet in the correct PE.
- Outputs drive the grid's left-edge input/valid pins and top-edge weight/valid pins directly.
- Frames one matrix tile of K_len steps with a start/done protocol and an internal drain phase.

Parameters:
- INPUT_WIDTH, 32, activation element width
- WEIGHT_WIDTH, 32, weight element width
- NUM_ROWS, 16, grid rows (activation lanes)
- NUM_COLS, 16, grid columns (weight lanes)
- K_WIDTH, 16, width of the tile-length field

Ports:
- clk_i  in  1  clock; the only clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  begin a tile; sampled only in IDLE.
- k_len_i  in  K_WIDTH  number of K-steps in the tile; latched when start_i is sampled.
- vec_valid_i  in  1  a K-step vector is presented.
- vec_ready_o  out  1  the feeder can accept a vector.
- in_vec_i  in  [NUM_ROWS] x INPUT_WIDTH  activation column.
- w_vec_i  in  [NUM_COLS] x WEIGHT_WIDTH  weight row.
- input_o  out  [NUM_ROWS] x INPUT_WIDTH  skewed activations, to the grid's left edge.
- input_valid_o  out  [NUM_ROWS] x 1  per-lane activation valid.
- weight_o  out  [NUM_COLS] x WEIGHT_WIDTH  skewed weights, to the grid's top edge.
- weight_valid_o  out  [NUM_COLS] x 1  per-lane weight valid.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at tile end.
- stall_cnt_o  out  32  bubble counter; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - All lane data and valid registers clear to 0.
  - Step and drain counters clear to 0.
  - Outputs vec_ready_o, busy_o and done_o are 0.
  - Reset asserted mid-tile aborts the tile: no done_o pulse, and valids are 0 on the cycle after reset is sampled.
- Define M = max(NUM_ROWS, NUM_COLS).
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE: vec_ready_o=0.
    - start_i=1 with k_len_i!=0: latch k_len, clear the step counter, go to STREAM.
    - start_i=1 with k_len_i==0: go to DONE; no valids are emitted.
  - STREAM: vec_ready_o=1.
    - Accept a vector when vec_valid_i & vec_ready_o. On acceptance, the step counter increments.
    - On acceptance of step k_len-1: go to DRAIN if M>1, otherwise go to DONE.
    - A cycle with no acceptance injects a bubble (valid=0) into every lane; the skew relationship is preserved.
  - DRAIN: vec_ready_o=0; bubbles are injected. Lasts exactly M-1 cycles, then goes to DONE.
  - DONE: done_o=1 for one cycle, then go to IDLE.
- start_i is ignored outside IDLE.
- Skew timing:
  - An element accepted in cycle t appears on input_o[r]/input_valid_o[r] during cycle t+1+r.
  - Likewise on weight_o[c]/weight_valid_o[c] during cycle t+1+c.
  - All outputs are registered; there is no combinational path from inputs to outputs.
  - done_o coincides with the last valid beat on lane M-1.
- Lane implementation: lane r is a register chain of depth r+1. Data and valid shift together every cycle; there is no back-pressure from the grid.
- Data on a lane whose valid=0 is don't-care; consumers qualify data with valid.
- k_len counting is unsigned K_WIDTH. The maximum k_len (2^K_WIDTH-1) must complete without counter wrap.

Optional Feature:
- Macro: SKEW_FEEDER_STALL_CNT_EN.
- Defined:
  - stall_cnt_o counts STREAM cycles with vec_valid_i=0.
  - The counter clears when a start_i is accepted in IDLE.
  - The counter holds its value in DRAIN, DONE and IDLE.
  - It saturates at 0xFFFFFFFF and is reset to 0.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is synthesised.

Test Plan:
- Config NUM_ROWS=NUM_COLS=4, k_len=3, vec_valid_i held high, vectors accepted in cycles 1,2,3:
  - input_valid_o[0] is high in cycles 2-4 and input_valid_o[3] is high in cycles 5-7.
  - Data matches the accepted vectors in order.
  - done_o is high only in cycle 7; busy_o falls in cycle 8.
- Same config, k_len=2, vec_valid_i low for 2 cycles between the two vectors:
  - A 2-cycle valid gap appears on every lane.
  - Lane 3 beats land 3 cycles after the corresponding lane 0 beats.
  - With SKEW_FEEDER_STALL_CNT_EN defined, stall_cnt_o=2.
- start_i with k_len_i=0:
  - done_o pulses 1 cycle after start is sampled.
  - No valid is ever asserted; vec_ready_o stays 0.
- rst_i asserted for 1 cycle during DRAIN:
  - All valids are 0 on the next cycle and the FSM is in IDLE.
  - No done_o pulse occurs; a new start then completes normally.
- start_i pulsed during STREAM:
  - Ignored; k_len is unchanged and the tile ends after the original count.
- NUM_ROWS=4, NUM_COLS=2, k_len=1, accepted in cycle 1:
  - weight_valid_o[1] is high in cycle 3 and input_valid_o[3] is high in cycle 5.
  - done_o is high in cycle 5.
